// File: rtl/uart_atoi.sv
// Streaming ASCII-decimal to signed 16-bit parser for the UART receive path.
// Whitespace/comma separated tokens; one o_en pulse per completed token.
module uart_atoi (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en,
    input  logic [7:0]         i_data,
    output logic               o_en,
    output logic signed [15:0] o_val,
    output logic               o_err
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_SIGN   = 2'd1;
    localparam logic [1:0]  ST_DIGITS = 2'd2;
    localparam logic [1:0]  ST_ERROR  = 2'd3;

    localparam logic [16:0] ACC_CLAMP = 17'd32769;
    localparam logic [16:0] POS_LIMIT = 17'd32767;
    localparam logic [16:0] NEG_LIMIT = 17'd32768;

    function automatic logic is_sep(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D) || (b == 8'h20) || (b == 8'h2C);
    endfunction

    function automatic logic is_sign(input logic [7:0] b);
        return (b == 8'h2D) || (b == 8'h2B);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    logic [1:0]         state_q, state_d;
    logic [16:0]        acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               o_en_q;
    logic signed [15:0] o_val_q, val_d;
    logic               o_err_q, err_d;

    logic               done_s;
    logic               bad_s;
    logic [16:0]        digit_s;
    logic [20:0]        acc_ext_s;
    logic [20:0]        acc_mac_s;
    logic [16:0]        acc_step_s;
    logic               ovf_step_s;

    // Multiply-accumulate by shift-add, widened so it can never wrap before clamping.
    always_comb begin
        digit_s    = {13'd0, i_data[3:0]};
        acc_ext_s  = {4'd0, acc_q};
        acc_mac_s  = (acc_ext_s << 3) + (acc_ext_s << 1) + {4'd0, digit_s};
        if (acc_mac_s > {4'd0, NEG_LIMIT}) begin
            acc_step_s = ACC_CLAMP;
            ovf_step_s = 1'b1;
        end else begin
            acc_step_s = acc_mac_s[16:0];
            ovf_step_s = ovf_q;
        end
    end

    // Token FSM: state only advances on a byte strobe.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        done_s  = 1'b0;
        bad_s   = 1'b0;
        if (i_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_sep(i_data)) begin
                        state_d = ST_IDLE;
                    end else if (is_sign(i_data)) begin
                        state_d = ST_SIGN;
                        neg_d   = (i_data == 8'h2D);
                    end else if (is_digit(i_data)) begin
                        state_d = ST_DIGITS;
                        acc_d   = digit_s;
                        neg_d   = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_SIGN: begin
                    if (is_digit(i_data)) begin
                        state_d = ST_DIGITS;
                        acc_d   = digit_s;
                    end else if (is_sep(i_data)) begin
                        done_s  = 1'b1;
                        bad_s   = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DIGITS: begin
                    if (is_digit(i_data)) begin
                        acc_d = acc_step_s;
                        ovf_d = ovf_step_s;
                    end else if (is_sep(i_data)) begin
                        done_s = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (is_sep(i_data)) begin
                        done_s = 1'b1;
                        bad_s  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (done_s) begin
                state_d = ST_IDLE;
                acc_d   = 17'd0;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                state_d = state_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Result of a completing token; -32768 falls out of two's complement negation of 0x8000.
    always_comb begin
        if (bad_s) begin
            val_d = 16'sd0;
            err_d = 1'b1;
        end else if (ovf_q || (acc_q > (neg_q ? NEG_LIMIT : POS_LIMIT))) begin
            val_d = neg_q ? 16'sh8000 : 16'sh7FFF;
            err_d = 1'b1;
        end else if (neg_q) begin
            val_d = 16'sd0 - $signed(acc_q[15:0]);
            err_d = 1'b0;
        end else begin
            val_d = $signed(acc_q[15:0]);
            err_d = 1'b0;
        end
    end

    // Parser state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            acc_q   <= 17'd0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            o_en_q  <= 1'b0;
            o_val_q <= 16'sd0;
            o_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            o_en_q  <= done_s;
            if (done_s) begin
                o_val_q <= val_d;
                o_err_q <= err_d;
            end else begin
                o_val_q <= o_val_q;
                o_err_q <= o_err_q;
            end
        end
    end

    assign o_en  = o_en_q;
    assign o_val = o_val_q;
    assign o_err = o_err_q;

endmodule

// File: tb/tb_uart_atoi.sv
// Scoreboard bench for uart_atoi: a token-level reference model predicts each
// pulse (value, error, cycle); a monitor pops and compares on every o_en.
module tb_uart_atoi;

    logic               clk;
    logic               rstn;
    logic               i_en;
    logic [7:0]         i_data;
    logic               o_en;
    logic signed [15:0] o_val;
    logic               o_err;

    uart_atoi dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (i_en),
        .i_data (i_data),
        .o_en   (o_en),
        .o_val  (o_val),
        .o_err  (o_err)
    );

    typedef struct {
        longint val;
        longint err;
        longint cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    byte unsigned tok_q[$];
    int           checks = 0;
    int           errors = 0;
    longint       cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_is_sep(input byte unsigned b);
        return b == 8'h0A || b == 8'h0D || b == 8'h20 || b == 8'h2C;
    endfunction

    // Evaluate a whole token: [sign] digit+ ; anything else is malformed.
    function automatic void close_token(input longint when);
        exp_t   e;
        bit     ok = 1'b1;
        bit     neg = 1'b0;
        int     start = 0;
        longint mag = 0;
        longint limit;
        if (tok_q[0] == 8'h2D || tok_q[0] == 8'h2B) begin
            neg   = (tok_q[0] == 8'h2D);
            start = 1;
        end
        if (start >= tok_q.size()) ok = 1'b0;
        for (int i = start; i < tok_q.size(); i++) begin
            if (tok_q[i] < 8'h30 || tok_q[i] > 8'h39) ok = 1'b0;
            else begin
                mag = mag * 10 + longint'(tok_q[i] - 8'h30);
                if (mag > 100000) mag = 100000;
            end
        end
        limit = neg ? 32768 : 32767;
        e.cyc = when;
        if (!ok) begin
            e.val = 0; e.err = 1;
        end else if (mag > limit) begin
            e.val = neg ? -32768 : 32767; e.err = 1;
        end else begin
            e.val = neg ? -mag : mag; e.err = 0;
        end
        exp_q.push_back(e);
    endfunction

    function automatic void model_byte(input byte unsigned b, input longint when);
        if (tb_is_sep(b)) begin
            if (tok_q.size() > 0) begin
                close_token(when);
                tok_q.delete();
            end
        end else begin
            tok_q.push_back(b);
        end
    endfunction

    // Called just after a falling edge; the byte is taken at the next rising edge.
    task automatic send_byte(input byte unsigned b, input int gap);
        i_data = b;
        i_en   = 1'b1;
        model_byte(b, cyc + 1);
        @(negedge clk);
        i_en   = 1'b0;
        i_data = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    endtask

    always @(negedge clk) begin
        if (o_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got o_val %0d o_err %0d expected no pulse", o_val, o_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("o_val", longint'(o_val), mon_e.val);
                check("o_err", longint'(o_err), mon_e.err);
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        byte unsigned gen_q[$];
        byte unsigned bad_chars[5];
        byte unsigned seps[4];
        int kind, nd, sg;
        bad_chars = '{8'h78, 8'h2E, 8'h09, 8'hFF, 8'h3A};
        seps      = '{8'h0A, 8'h0D, 8'h20, 8'h2C};

        rstn = 1'b0; i_en = 1'b0; i_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_o_en", longint'(o_en), 0);
        check("rst_o_val", longint'(o_val), 0);
        check("rst_o_err", longint'(o_err), 0);
        rstn = 1'b1;
        @(negedge clk);

        send_str("-1234\n", 0);
        repeat (20) @(negedge clk);
        check("hold_o_val", longint'(o_val), -1234);
        check("hold_o_err", longint'(o_err), 0);

        send_str("  +32767 ", 0);
        send_str("-32768", 0);
        send_byte(8'h0D, 0);
        send_str("40000\n", 0);
        send_str("-9999999999,", 0);
        send_str("32768\n", 0);
        send_str("12a3\n", 0);
        send_str("-\n", 0);
        send_str("5-\n", 0);
        send_str("7,", 0);
        send_str("-0 007,", 0);
        send_str("1,2,,3\n", 0);
        send_str("1,2,,3\n", 5);

        // Reset mid-token discards the partial "12".
        send_str("12", 0);
        rstn = 1'b0;
        tok_q.delete();
        @(negedge clk);
        check("midrst_o_en", longint'(o_en), 0);
        check("midrst_o_val", longint'(o_val), 0);
        check("midrst_o_err", longint'(o_err), 0);
        rstn = 1'b1;
        @(negedge clk);
        send_str("5\n", 0);

        for (int t = 0; t < 150; t++) begin
            gen_q.delete();
            kind = int'($urandom_range(9, 0));
            sg   = int'($urandom_range(2, 0));
            if (sg == 1) gen_q.push_back(8'h2D);
            else if (sg == 2) gen_q.push_back(8'h2B);
            if (kind != 0) begin
                nd = (kind == 2) ? int'($urandom_range(12, 5)) : int'($urandom_range(5, 1));
                for (int d = 0; d < nd; d++)
                    gen_q.push_back(8'h30 + 8'($urandom_range(9, 0)));
            end
            if (kind == 1)
                gen_q.insert(int'($urandom_range(gen_q.size(), 0)), bad_chars[$urandom_range(4, 0)]);
            if (kind == 0 && sg == 0) gen_q.push_back(8'h2B);
            foreach (gen_q[k]) send_byte(gen_q[k], int'($urandom_range(2, 0)));
            nd = int'($urandom_range(2, 1));
            for (int s = 0; s < nd; s++)
                send_byte(seps[$urandom_range(3, 0)], int'($urandom_range(3, 0)));
        end

        repeat (4) @(negedge clk);
        check("pending_expectations", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
